// File: rtl/mtm_Alu_pkg.sv
// Shared definitions for the ALU serial link: frame format, state encoding,
// flag/error bit positions and the CRC3 used by both link ends.
package mtm_Alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CTL,
    S_ERR
  } state_t;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD  = 1'b1;

  localparam int FRAME_BITS  = 11;
  localparam int DATA_FRAMES = 4;
  localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);
  localparam logic [1:0] LAST_FRAME = 2'(DATA_FRAMES - 1);

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 0;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam logic [2:0] CRC3_POLY     = 3'b011;  // x^3 + x + 1, x^3 implicit
  localparam int         CRC_WORD_BITS = 37;

  function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic din);
    logic       fb;
    logic [2:0] shifted;
    fb      = crc[2] ^ din;
    shifted = {crc[1:0], 1'b0};
    return fb ? (shifted ^ CRC3_POLY) : shifted;
  endfunction

  function automatic logic [2:0] crc3_d37(input logic [CRC_WORD_BITS-1:0] word);
    logic [2:0] crc;
    crc = 3'b000;
    for (int i = CRC_WORD_BITS - 1; i >= 0; i--) begin
      crc = crc3_step(crc, word[i]);
    end
    return crc;
  endfunction

  function automatic logic [7:0] ctl_payload(input logic [3:0] flags, input logic [2:0] crc);
    return {1'b0, flags[FLAG_CARRY], flags[FLAG_OVF], flags[FLAG_ZERO], flags[FLAG_NEG], crc};
  endfunction

  function automatic logic [7:0] err_payload(input logic [2:0] err_flags);
    logic [2:0] e;
    logic [6:0] body;
    e    = {err_flags[ERR_DATA], err_flags[ERR_CRC], err_flags[ERR_OP]};
    body = {1'b1, e, e};
    return {body, ^body};  // trailing bit makes the payload parity even
  endfunction

endpackage

// File: rtl/mtm_Alu_crc3.sv
// Serial CRC3 LFSR, MSB-first, zero initial value, no final XOR.
module mtm_Alu_crc3
  import mtm_Alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [2:0] crc
);

  // NOTE: sequential state is always assigned with <= so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= 3'b000;
    end else if (en) begin
      crc <= crc3_step(crc, din);
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Transmit side of the ALU serial link: sends one result packet (4 DATA
// frames + CMD frame with flags/CRC) or one error frame on sout.
module mtm_alu_serializer
  import mtm_Alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        is_err,
  input  logic [31:0] C,
  input  logic [3:0]  flags,
  input  logic [2:0]  err_flags,
  output logic        ready,
  output logic        sout
);

  localparam logic [5:0] CRC_LAST    = 6'(CRC_WORD_BITS - 1);
  localparam logic [5:0] CRC_IDX_END = 6'(CRC_WORD_BITS);

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [1:0]  frame_cnt;
  logic [5:0]  crc_idx;
  logic [31:0] c_q;
  logic [3:0]  flags_q;
  logic [2:0]  err_q;
  logic        is_err_q;
  logic [9:0]  shreg;

  logic        accept;
  logic        crc_en;
  logic        crc_din;
  logic [2:0]  crc;
  logic [CRC_WORD_BITS-1:0] crc_word;
  logic [7:0]  data_byte;
  logic [9:0]  load_word;

  assign ready  = (state == S_IDLE);
  assign accept = ready && valid;

  // The CRC is fed from the captured fields one bit per cycle during DATA;
  // 37 bits finish well before the CMD frame payload is loaded.
  assign crc_word = {c_q, 1'b0, flags_q};
  assign crc_en   = (state == S_DATA) && (crc_idx < CRC_IDX_END);
  assign crc_din  = crc_word[CRC_LAST - crc_idx];

  mtm_Alu_crc3 u_crc3 (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    data_byte = c_q[7:0];
    case (frame_cnt)
      2'd0:    data_byte = c_q[31:24];
      2'd1:    data_byte = c_q[23:16];
      2'd2:    data_byte = c_q[15:8];
      default: data_byte = c_q[7:0];
    endcase
  end

  // {type, payload, stop}: everything after the start bit of a frame
  always_comb begin
    load_word = {TYPE_DATA, data_byte, 1'b1};
    if (is_err_q) begin
      load_word = {TYPE_CMD, err_payload(err_q), 1'b1};
    end else if (state == S_CTL) begin
      load_word = {TYPE_CMD, ctl_payload(flags_q, crc), 1'b1};
    end
  end

  // bit_cnt names the frame bit currently on sout; the start bit goes out
  // directly, the rest of the frame is loaded from the captured fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sout      <= 1'b1;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      crc_idx   <= '0;
      c_q       <= '0;
      flags_q   <= '0;
      err_q     <= '0;
      is_err_q  <= 1'b0;
      shreg     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sout <= 1'b1;
          if (valid) begin
            c_q       <= C;
            flags_q   <= flags;
            err_q     <= err_flags;
            is_err_q  <= is_err;
            state     <= is_err ? S_ERR : S_DATA;
            sout      <= 1'b0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            crc_idx   <= '0;
          end
        end
        default: begin
          if (crc_en) begin
            crc_idx <= crc_idx + 6'd1;
          end
          if (bit_cnt == 4'd0) begin
            sout    <= load_word[9];
            shreg   <= {load_word[8:0], 1'b1};
            bit_cnt <= 4'd1;
          end else if (bit_cnt != LAST_BIT) begin
            sout    <= shreg[9];
            shreg   <= {shreg[8:0], 1'b1};
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            bit_cnt <= 4'd0;
            if (state == S_DATA && frame_cnt != LAST_FRAME) begin
              frame_cnt <= frame_cnt + 2'd1;
              sout      <= 1'b0;
            end else if (state == S_DATA) begin
              state     <= S_CTL;
              frame_cnt <= '0;
              sout      <= 1'b0;
            end else begin
              state <= S_IDLE;
              sout  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: directed and random packets
// against a bit-level frame model built from plain arithmetic.
module tb_mtm_alu_serializer;
  import mtm_Alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        is_err;
  logic [31:0] C;
  logic [3:0]  flags;
  logic [2:0]  err_flags;
  logic        ready;
  logic        sout;

  int n_checks = 0;
  int n_errors = 0;

  mtm_alu_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .is_err    (is_err),
    .C         (C),
    .flags     (flags),
    .err_flags (err_flags),
    .ready     (ready),
    .sout      (sout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of ({C,0,flags} * x^3) divided by x^3+x+1
  function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  function automatic logic [10:0] ref_frame(input logic t, input logic [7:0] payload);
    return {1'b0, t, payload, 1'b1};
  endfunction

  function automatic logic [54:0] ref_result(input logic [31:0] c, input logic [3:0] f);
    logic [7:0] ctl;
    ctl = {1'b0, f, ref_crc(c, f)};
    return {ref_frame(1'b0, 8'((c >> 24) & 32'hFF)), ref_frame(1'b0, 8'((c >> 16) & 32'hFF)),
            ref_frame(1'b0, 8'((c >> 8) & 32'hFF)), ref_frame(1'b0, 8'(c & 32'hFF)),
            ref_frame(1'b1, ctl)};
  endfunction

  function automatic logic [10:0] ref_err(input logic [2:0] e);
    logic [7:0] p;
    p = {1'b1, e, e, 1'b0};
    if ($countones(p) % 2 == 1) p[0] = 1'b1;
    return ref_frame(1'b1, p);
  endfunction

  // Called at a negedge with the DUT idle. pulse_at > 0 raises valid during
  // that bit; rst_at > 0 asserts reset during that bit and abandons the packet.
  task automatic send_pkt(input string tag, input logic err, input logic [31:0] c,
                          input logic [3:0] f, input logic [2:0] e,
                          input int pulse_at, input int rst_at);
    logic [54:0] obs;
    logic [54:0] exp;
    int          len;
    int          ready_hi;
    int          idle_bad;
    len = err ? 11 : 55;
    exp = err ? 55'(ref_err(e)) : ref_result(c, f);
    check({tag, "_ready_pre"}, 64'(ready), 64'd1);
    valid = 1'b1; is_err = err; C = c; flags = f; err_flags = e;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; is_err = ~err; C = $urandom; flags = 4'($urandom); err_flags = 3'($urandom);
    obs = '0;
    ready_hi = 0;
    for (int k = 1; k <= len; k++) begin
      if (k > 1) @(negedge clk);
      obs = {obs[53:0], sout};
      if (ready) ready_hi++;
      valid = (k == pulse_at);
      if (k == rst_at) begin
        rst = 1'b1;
        break;
      end
    end
    if (rst_at > 0) begin
      check({tag, "_partial"}, 64'(obs), 64'(exp >> (len - rst_at)));
      @(negedge clk);
      check({tag, "_rst_sout"}, 64'(sout), 64'd1);
      check({tag, "_rst_ready"}, 64'(ready), 64'd1);
      rst = 1'b0;
    end else begin
      check({tag, "_bits"}, 64'(obs), 64'(exp));
      check({tag, "_ready_busy"}, 64'(ready_hi), 64'd0);
      @(negedge clk);
      check({tag, "_ready_ret"}, 64'(ready), 64'd1);
      check({tag, "_sout_idle"}, 64'(sout), 64'd1);
      if (pulse_at > 0) begin
        idle_bad = 0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (sout !== 1'b1 || ready !== 1'b1) idle_bad++;
        end
        check({tag, "_no_queue"}, 64'(idle_bad), 64'd0);
      end
    end
  endtask

  initial begin
    int          idle_bad;
    logic [31:0] rc;
    logic [3:0]  rf;
    logic [2:0]  re;
    logic        rerr;

    rst = 1'b1; valid = 1'b1; is_err = 1'b0; C = 32'hDEADBEEF; flags = 4'hF; err_flags = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sout", 64'(sout), 64'd1);
    check("reset_ready", 64'(ready), 64'd1);
    rst = 1'b0; valid = 1'b0;
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sout !== 1'b1 || ready !== 1'b1) idle_bad++;
    end
    check("idle_after_reset", 64'(idle_bad), 64'd0);

    check("crc_zero_f1", 64'(ref_crc(32'h0, 4'b0001)), 64'h3);
    check("pkg_crc_12345678", 64'(crc3_d37({32'h12345678, 1'b0, 4'h0})),
          64'(ref_crc(32'h12345678, 4'h0)));

    send_pkt("zero",      1'b0, 32'h0000_0000, 4'b0000, 3'b000, 0, 0);
    send_pkt("crc_f1",    1'b0, 32'h0000_0000, 4'b0001, 3'b000, 0, 0);
    send_pkt("order",     1'b0, 32'h1234_5678, 4'b0000, 3'b000, 0, 0);
    send_pkt("err100",    1'b1, 32'hFFFF_FFFF, 4'b1111, 3'b100, 0, 0);
    send_pkt("mid_valid", 1'b0, 32'hA5C3_0F96, 4'b1010, 3'b000, 20, 0);
    send_pkt("rst_mid",   1'b0, 32'hCAFE_F00D, 4'b0110, 3'b000, 0, 30);
    send_pkt("fresh",     1'b0, 32'h8000_0001, 4'b1001, 3'b000, 0, 0);

    for (int n = 0; n < 24; n++) begin
      rc   = $urandom;
      rf   = 4'($urandom);
      re   = 3'($urandom);
      rerr = ($urandom_range(0, 3) == 0);
      send_pkt($sformatf("rand%0d", n), rerr, rc, rf, re, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
